servo_pwm_decoder: RTL

SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

---
 rtl/servo_pwm_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the pulse width of an asynchronous servo signal in
// 2 us ticks, converts it to an angle of 0..180 degrees and monitors signal loss.
module servo_pwm_decoder #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_upd,
  output logic       signal_ok,
  output logic       pulse_err
);

  localparam int TICK_DIV = CLK_FREQ / 500_000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [13:0] TIMEOUT_TICKS = 14'd12500;
  localparam logic [10:0] W_MIN  = 11'd225;
  localparam logic [10:0] W_ZERO = 11'd250;
  localparam logic [10:0] W_FULL = 11'd1250;
  localparam logic [10:0] W_MAX  = 11'd1275;
  localparam logic [10:0] W_SAT  = 11'd2047;

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } state_t;

  logic          meta_r;
  logic          sync_r;
  logic          sync_d_r;
  logic [1:0]    fill_r;
  logic [PW-1:0] presc_r;
  logic [10:0]   width_r;
  logic [13:0]   timeout_r;
  state_t        state_r;
  logic          cap_vld_r;
  logic [10:0]   cap_width_r;

  logic          rise_s;
  logic          fall_s;
  logic          wrap_s;
  logic          timeout_hit_s;
  logic [10:0]   width_eff_s;
  logic [8:0]    class_s;

  // Returns {accepted, angle} for a measured width in 2 us units.
  function automatic logic [8:0] classify(input logic [10:0] w);
    logic [17:0] offs;
    logic [17:0] prod;
    logic [17:0] quot;
    logic [8:0]  res;
    offs = {7'd0, w - W_ZERO};
    prod = offs * 18'd180;
    quot = prod / 18'd1000;
    if ((w < W_MIN) || (w > W_MAX)) begin
      res = {1'b0, 8'd0};
    end else if (w <= W_ZERO) begin
      res = {1'b1, 8'd0};
    end else if (w >= W_FULL) begin
      res = {1'b1, 8'd180};
    end else begin
      res = {1'b1, quot[7:0]};
    end
    return res;
  endfunction

  assign rise_s        = sync_r & ~sync_d_r;
  assign fall_s        = ~sync_r & sync_d_r;
  assign wrap_s        = (presc_r == PRESC_MAX);
  assign timeout_hit_s = wrap_s && !rise_s && (timeout_r == (TIMEOUT_TICKS - 14'd1));
  // The falling-edge cycle's own wrap is included so width = floor(high clocks / TICK_DIV).
  assign width_eff_s   = (wrap_s && (width_r != W_SAT)) ? (width_r + 11'd1) : width_r;
  assign class_s       = classify(cap_width_r);

  // Two-flop synchronizer, delayed copy for edge detection, and fill tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      sync_d_r <= 1'b0;
      fill_r   <= 2'b00;
    end else begin
      meta_r   <= pwm_in;
      sync_r   <= meta_r;
      sync_d_r <= sync_r;
      fill_r   <= {fill_r[0], 1'b1};
    end
  end

  // Tick prescaler, re-phased on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (rise_s || wrap_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Pulse width counter in ticks, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_r <= 11'd0;
    end else if (rise_s) begin
      width_r <= 11'd0;
    end else if ((state_r == HIGH) && wrap_s && (width_r != W_SAT)) begin
      width_r <= width_r + 11'd1;
    end else begin
      width_r <= width_r;
    end
  end

  // Ticks since the last rising edge, saturating at the loss-of-signal limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_r <= 14'd0;
    end else if (rise_s) begin
      timeout_r <= 14'd0;
    end else if (wrap_s && (timeout_r != TIMEOUT_TICKS)) begin
      timeout_r <= timeout_r + 14'd1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  // Pulse tracking FSM; captures the width on each falling edge seen in HIGH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SYNC;
      cap_vld_r   <= 1'b0;
      cap_width_r <= 11'd0;
    end else begin
      cap_vld_r <= 1'b0;
      if (timeout_hit_s) begin
        state_r <= SYNC;
      end else begin
        case (state_r)
          // Only trust the synchronizer once it holds post-reset samples.
          SYNC: begin
            if (fill_r[1] && !sync_r) begin
              state_r <= WAIT_RISE;
            end else begin
              state_r <= SYNC;
            end
          end
          WAIT_RISE: begin
            if (rise_s) begin
              state_r <= HIGH;
            end else begin
              state_r <= WAIT_RISE;
            end
          end
          HIGH: begin
            if (fall_s) begin
              state_r     <= WAIT_RISE;
              cap_vld_r   <= 1'b1;
              cap_width_r <= width_eff_s;
            end else begin
              state_r <= HIGH;
            end
          end
          default: begin
            state_r <= SYNC;
          end
        endcase
      end
    end
  end

  // Registered result stage: angle update, error strobe and signal health.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle     <= 8'd0;
      angle_upd <= 1'b0;
      pulse_err <= 1'b0;
      signal_ok <= 1'b0;
    end else begin
      angle_upd <= 1'b0;
      pulse_err <= 1'b0;
      if (cap_vld_r) begin
        if (class_s[8]) begin
          angle     <= class_s[7:0];
          angle_upd <= 1'b1;
          signal_ok <= 1'b1;
        end else begin
          pulse_err <= 1'b1;
          signal_ok <= 1'b0;
        end
      end else if (timeout_hit_s) begin
        signal_ok <= 1'b0;
      end else begin
        signal_ok <= signal_ok;
      end
    end
  end

endmodule
